effect_chain: RTL and testbench
===============================

EFFECT_CHAIN -- requirements
Module: effect_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width.
REQ-002 SHALL have parameter CHANNELS, default 2: interleaved channels, range 1..8; CH_W = max(1, clog2(CHANNELS)).
REQ-003 SHALL have parameter AVG_LOG2, default 2: moving-average window of 2^AVG_LOG2 samples per channel.
REQ-004 SHALL have parameter DELAY_DEPTH, default 1024: echo delay in samples per channel, power of 2.
REQ-005 SHALL have parameter NOISE_THRESH, default 64: noise-gate magnitude threshold.
REQ-006 SHALL have ports: clk_clk in 1, the single clock; reset_reset_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: in_valid in 1; in_ready out 1; in_data in DATA_W; in_channel in CH_W -- input stream.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_data out DATA_W; out_channel out CH_W -- output stream.
REQ-009 SHALL have ports: key_n in 2, active-low pushbuttons; switch_avg, switch_delay, switch_noise in 1 each.
REQ-010 SHALL have ports: led out 10, gain bar; hex out 7, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-011 SHALL transfer a sample when valid and ready are both high in the same cycle.
REQ-012 SHALL implement a 3-stage pipeline (average, delay, gain) that advances only when out_ready is high or out_valid is low; in_ready equals that advance condition.
REQ-013 SHALL give latency of exactly 3 cycles from input accept to out_valid with no backpressure; out_channel SHALL equal the accepted in_channel.
REQ-014 SHALL hold out_data/out_channel stable while out_valid is high and out_ready is low.
REQ-015 Stage 1 SHALL keep a per-channel history of the last 2^AVG_LOG2 samples, always updated; result = sum >>> AVG_LOG2 (sign-extended, no overflow) when switch_avg is high, else the sample itself.
REQ-016 Stage 2 SHALL keep a per-channel circular buffer of DELAY_DEPTH samples, written every accepted sample; when switch_delay is high, result = (x >>> 1) + (d >>> 1), where d is the sample written DELAY_DEPTH accepts earlier on that channel; otherwise result = x.
REQ-017 d SHALL read as 0 until the channel's write pointer has wrapped at least once since reset.
REQ-018 Stage 3 SHALL compute (x * gain) >>> 2 and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 gain SHALL be a 4-bit register, range 0..9; gain 4 is unity.
REQ-020 key_n bits SHALL be 2-flop synchronised and then edge-detected on press (1->0).
REQ-021 A key_n[0] press SHALL increment gain, saturating at 9; a key_n[1] press SHALL decrement gain, saturating at 0.
REQ-022 Simultaneous presses in the same cycle SHALL set gain to 4.
REQ-023 A gain change SHALL apply to samples entering stage 3 on the following cycle.
REQ-024 Switch inputs SHALL be 2-flop synchronised; a switch change SHALL take effect on samples entering the affected stage after synchronisation and SHALL NOT clear history or delay buffers.
REQ-025 led[i] SHALL be high iff i < gain.
REQ-026 hex SHALL display the decimal digit of gain, active-low.
REQ-027 An out-of-range in_channel (>= CHANNELS) SHALL be accepted and dropped, producing no output.

Reset
REQ-028 While reset_reset_n is low, the block SHALL set: out_valid 0, in_ready 0, out_data 0, out_channel 0, gain 4, led 10'b0000001111, hex showing "4", synchronisers to idle, history sums and pointers 0, wrap flags 0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; in_ready SHALL go high on the first clock after deassertion.
REQ-030 Buffer RAM contents need not be cleared; REQ-017 governs reads after reset.

Configuration
REQ-031 With macro NOISE_GATE_EN defined, stage 3 SHALL output 0 for samples with |x| < NOISE_THRESH (before gain) when switch_noise is high.
REQ-032 Without NOISE_GATE_EN, switch_noise SHALL be ignored, the port SHALL remain, and no comparator logic SHALL be built.

Verification
REQ-033 Bench SHALL cover: switches off, gain 4, in 1000 ch0 -> out 1000 ch0 after 3 cycles.
REQ-034 Bench SHALL cover: switch_avg on, AVG_LOG2=2, ch0 inputs 4,8,12,16 -> fourth output 10; ch1 history unaffected.
REQ-035 Bench SHALL cover: switch_delay on, DELAY_DEPTH=4, ch0 inputs 100,0,0,0,0 -> outputs 50,0,0,0,0; after the wrap, a further 100 -> 100.
REQ-036 Bench SHALL cover: seven key_n[0] presses from reset -> gain 9, led 0x1FF, hex "9"; input 30000 -> out 32767.
REQ-037 Bench SHALL cover: out_ready low for 5 cycles with in_valid held -> in_ready low, out_data stable, no sample lost or duplicated.
REQ-038 Bench SHALL cover: NOISE_GATE_EN defined, switch_noise on, inputs 50 and -63 -> 0 and 0; input 64 -> 64.

Source files
------------

// File: rtl/effect_chain.sv
// effect_chain: three-stage streaming audio effect pipeline for interleaved
// multi-channel signed samples.
//
//   stage 1  per-channel moving average over 2^AVG_LOG2 samples (switch_avg)
//   stage 2  per-channel echo: (x >>> 1) + (d >>> 1), d from DELAY_DEPTH
//            accepts earlier on the same channel (switch_delay)
//   stage 3  gain (x * gain) >>> 2 with saturation, gain 0..9, 4 = unity
//
// Optional feature: define NOISE_GATE_EN to build a noise gate in stage 3
// that zeroes samples with |x| < NOISE_THRESH while switch_noise is high.
// Without the macro switch_noise is accepted but unused.
//
// Ports
//   clk_clk, reset_reset_n             clock, async active-low reset
//   in_valid/in_ready/in_data/in_channel      input stream
//   out_valid/out_ready/out_data/out_channel  output stream
//   key_n[1:0]                         active-low buttons: [0] gain up, [1] gain down
//   switch_avg/switch_delay/switch_noise      effect enables (asynchronous)
//   led[9:0]                           gain bar, led[i] = (i < gain)
//   hex[6:0]                           gain digit, active-low {g,f,e,d,c,b,a}
module effect_chain #(
    parameter int DATA_W       = 16,
    parameter int CHANNELS     = 2,
    parameter int AVG_LOG2     = 2,
    parameter int DELAY_DEPTH  = 1024,
    parameter int NOISE_THRESH = 64,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_channel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_channel,
    input  logic [1:0]        key_n,
    input  logic              switch_avg,
    input  logic              switch_delay,
    input  logic              switch_noise,
    output logic [9:0]        led,
    output logic [6:0]        hex
);

    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int HP_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DP_W  = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);
    localparam logic signed [DATA_W+4:0] SAT_MAX =
        (DATA_W + 5)'({1'b0, {(DATA_W - 1){1'b1}}});
    localparam logic signed [DATA_W+4:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Synchronisers, key edge detect, gain register
    // ------------------------------------------------------------------
    logic [1:0] r_key_s1, r_key_s2, r_key_d;
    logic [1:0] r_sw_s1, r_sw_s2;          // {delay, avg}
    logic [3:0] r_gain;
    logic [1:0] w_press;

    assign w_press = r_key_d & ~r_key_s2;  // 1 -> 0 transition

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_key_d  <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_gain   <= 4'd4;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
            r_sw_s1  <= {switch_delay, switch_avg};
            r_sw_s2  <= r_sw_s1;
            if (w_press == 2'b11) begin
                r_gain <= 4'd4;
            end else if (w_press[0]) begin
                r_gain <= (r_gain >= 4'd9) ? 4'd9 : r_gain + 4'd1;
            end else if (w_press[1]) begin
                r_gain <= (r_gain == 4'd0) ? 4'd0 : r_gain - 4'd1;
            end
        end
    end

`ifdef NOISE_GATE_EN
    logic [1:0] r_nz_s;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_nz_s <= '0;
        end else begin
            r_nz_s <= {r_nz_s[0], switch_noise};
        end
    end
`else
    logic w_unused_noise;
    assign w_unused_noise = switch_noise;
`endif

    // ------------------------------------------------------------------
    // Flow control: every stage moves together when the output slot frees.
    // r_run keeps in_ready low while in reset and for the release edge.
    // ------------------------------------------------------------------
    logic r_run;
    logic w_adv, w_acc, w_ch_ok;
    logic r_out_valid;

    assign w_adv    = r_run & (out_ready | ~r_out_valid);
    assign in_ready = w_adv;
    assign w_acc    = in_valid & w_adv;
    assign w_ch_ok  = ({1'b0, in_channel} < CH_LIM);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_run <= 1'b0;
        else                r_run <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Stage 1: moving average (running sum minus evicted sample)
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] r_hist [CHANNELS][AVG_N];
    logic signed [SUM_W-1:0]  r_sum  [CHANNELS];
    logic [HP_W-1:0]          r_hptr [CHANNELS];
    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_data;
    logic [CH_W-1:0]          r_s1_ch;

    logic signed [DATA_W-1:0] w_old, w_avg, w_s1_res;
    logic signed [SUM_W-1:0]  w_sum_new;

    assign w_old     = r_hist[in_channel][r_hptr[in_channel]];
    assign w_sum_new = r_sum[in_channel] - SUM_W'(w_old) + SUM_W'($signed(in_data));
    assign w_avg     = DATA_W'(w_sum_new >>> AVG_LOG2);
    assign w_s1_res  = r_sw_s2[0] ? w_avg : $signed(in_data);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned k = 0; k < AVG_N; k++) r_hist[c][k] <= '0;
                r_sum[c]  <= '0;
                r_hptr[c] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ch    <= '0;
        end else if (w_adv) begin
            // out-of-range channels are consumed here and never reach stage 2
            r_s1_valid <= w_acc & w_ch_ok;
            r_s1_data  <= w_s1_res;
            r_s1_ch    <= in_channel;
            if (w_acc && w_ch_ok) begin
                r_hist[in_channel][r_hptr[in_channel]] <= $signed(in_data);
                r_sum[in_channel]  <= w_sum_new;
                r_hptr[in_channel] <= (r_hptr[in_channel] == HP_W'(AVG_N - 1)) ?
                                      '0 : r_hptr[in_channel] + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: echo. Read-before-write at the write pointer yields the
    // sample from DELAY_DEPTH accepts ago; r_wrap masks stale RAM.
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] r_dmem [CHANNELS][DELAY_DEPTH];
    logic [DP_W-1:0]          r_wptr [CHANNELS];
    logic                     r_wrap [CHANNELS];
    logic                     r_s2_valid;
    logic signed [DATA_W-1:0] r_s2_data;
    logic [CH_W-1:0]          r_s2_ch;

    logic signed [DATA_W-1:0] w_d, w_s2_res;
    logic                     w_wr;

    assign w_wr     = w_adv & r_s1_valid;
    assign w_d      = r_wrap[r_s1_ch] ? r_dmem[r_s1_ch][r_wptr[r_s1_ch]] : '0;
    assign w_s2_res = r_sw_s2[1] ? (r_s1_data >>> 1) + (w_d >>> 1) : r_s1_data;

    always_ff @(posedge clk_clk) begin
        if (w_wr) r_dmem[r_s1_ch][r_wptr[r_s1_ch]] <= r_s1_data;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_wrap[c] <= 1'b0;
            end
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ch    <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_s2_res;
            r_s2_ch    <= r_s1_ch;
            if (r_s1_valid) begin
                r_wptr[r_s1_ch] <= r_wptr[r_s1_ch] + 1'b1;
                if (r_wptr[r_s1_ch] == DP_W'(DELAY_DEPTH - 1)) r_wrap[r_s1_ch] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: gain with saturation (optional noise gate)
    // ------------------------------------------------------------------
    logic signed [DATA_W+4:0] w_prod, w_shift;
    logic signed [DATA_W-1:0] w_sat, w_s3_res;
    logic [DATA_W-1:0]        r_out_data;
    logic [CH_W-1:0]          r_out_ch;

    assign w_prod  = (DATA_W + 5)'(r_s2_data) * (DATA_W + 5)'($signed({1'b0, r_gain}));
    assign w_shift = w_prod >>> 2;
    assign w_sat   = (w_shift > SAT_MAX) ? DATA_W'(SAT_MAX) :
                     (w_shift < SAT_MIN) ? DATA_W'(SAT_MIN) : DATA_W'(w_shift);

`ifdef NOISE_GATE_EN
    localparam logic signed [DATA_W:0] NT_P = (DATA_W + 1)'(NOISE_THRESH);
    localparam logic signed [DATA_W:0] NT_N = -NT_P;
    logic signed [DATA_W:0] w_x_ext;
    logic                   w_gate;
    assign w_x_ext  = (DATA_W + 1)'(r_s2_data);
    assign w_gate   = r_nz_s[1] & (w_x_ext < NT_P) & (w_x_ext > NT_N);
    assign w_s3_res = w_gate ? '0 : w_sat;
`else
    assign w_s3_res = w_sat;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= w_s3_res;
            r_out_ch    <= r_s2_ch;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_ch;

    // ------------------------------------------------------------------
    // Gain display
    // ------------------------------------------------------------------
    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < 10; i++) led[i] = (i < 32'(r_gain));
    end

    always_comb begin
        hex = 7'h7F;
        case (r_gain)
            4'd0: hex = 7'h40;
            4'd1: hex = 7'h79;
            4'd2: hex = 7'h24;
            4'd3: hex = 7'h30;
            4'd4: hex = 7'h19;
            4'd5: hex = 7'h12;
            4'd6: hex = 7'h02;
            4'd7: hex = 7'h78;
            4'd8: hex = 7'h00;
            4'd9: hex = 7'h10;
            default: hex = 7'h7F;
        endcase
    end

endmodule

// File: tb/tb_effect_chain.sv
module tb_effect_chain;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [0:0]  in_channel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [0:0]  out_channel;
    logic [1:0]  key_n;
    logic        switch_avg, switch_delay, switch_noise;
    logic [9:0]  led;
    logic [6:0]  hex;

    always #5 clk_clk = ~clk_clk;

    effect_chain #(
        .DATA_W(16), .CHANNELS(2), .AVG_LOG2(2), .DELAY_DEPTH(4), .NOISE_THRESH(64)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_channel(in_channel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel),
        .key_n(key_n), .switch_avg(switch_avg), .switch_delay(switch_delay),
        .switch_noise(switch_noise), .led(led), .hex(hex)
    );

    typedef struct {
        bit rst;   // mid-stream reset before this vector
        bit avg;
        bit dly;
        int din;
        int ch;
        int exp;
    } vec_t;

    vec_t tv[20];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic plain_reset();
        @(negedge clk_clk);
        in_valid = 1'b0;
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    task automatic mid_reset();
        bit seen;
        @(negedge clk_clk);
        in_valid = 1'b1; in_data = 16'd777; in_channel = 1'b0;
        @(posedge clk_clk);
        #1 in_valid = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1 chk("ready after release", int'(in_ready), 1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flushed sample", int'(seen), 0);
    endtask

    task automatic send_one(input int din, input int ch, input int exp, input string nm);
        int lat;
        bit got;
        @(negedge clk_clk);
        in_valid = 1'b1; in_data = 16'(din); in_channel = 1'(ch);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (in_ready) got = 1'b1;
            @(posedge clk_clk);
        end
        #1 in_valid = 1'b0;
        if (!got) chk({nm, " accept timeout"}, 0, 1);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk_clk);
            if (out_valid) begin got = 1'b1; lat = i; end
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " data"}, int'($signed(out_data)), exp);
        chk({nm, " chan"}, int'(out_channel), ch);
        @(posedge clk_clk);
    endtask

    task automatic press(input logic [1:0] m);
        @(negedge clk_clk);
        key_n = ~m;
        repeat (5) @(negedge clk_clk);
        key_n = 2'b11;
        repeat (5) @(negedge clk_clk);
    endtask

    initial begin
        int vals[12];
        int rx_d[$];
        int rx_c[$];
        int sent;
        bit acc;

        //             rst avg dly   din  ch   exp
        tv[0]  = '{1'b0, 1'b0, 1'b0,  1000, 0,  1000};
        tv[1]  = '{1'b0, 1'b1, 1'b0,     4, 0,   251};
        tv[2]  = '{1'b0, 1'b1, 1'b0,     8, 0,   253};
        tv[3]  = '{1'b0, 1'b1, 1'b0,    12, 0,   256};
        tv[4]  = '{1'b0, 1'b1, 1'b0,    16, 0,    10};
        tv[5]  = '{1'b0, 1'b1, 1'b0,   400, 1,   100};
        tv[6]  = '{1'b0, 1'b1, 1'b0,   400, 1,   200};
        tv[7]  = '{1'b0, 1'b1, 1'b0,    20, 0,    14};
        tv[8]  = '{1'b1, 1'b0, 1'b1,   300, 1,   150};
        tv[9]  = '{1'b0, 1'b0, 1'b1,   100, 0,    50};
        tv[10] = '{1'b0, 1'b0, 1'b1,     0, 0,     0};
        tv[11] = '{1'b0, 1'b0, 1'b1,     0, 0,     0};
        tv[12] = '{1'b0, 1'b0, 1'b1,     0, 0,     0};
        tv[13] = '{1'b0, 1'b0, 1'b1,   100, 0,   100};
        tv[14] = '{1'b0, 1'b0, 1'b1,  -200, 1,  -100};
        tv[15] = '{1'b0, 1'b0, 1'b0,    60, 0,    60};
        tv[16] = '{1'b0, 1'b0, 1'b1,     0, 0,     0};
        tv[17] = '{1'b0, 1'b0, 1'b1,     0, 0,     0};
        tv[18] = '{1'b0, 1'b0, 1'b1,     0, 0,    50};
        tv[19] = '{1'b0, 1'b0, 1'b1,     0, 0,    30};

        reset_reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_channel = '0;
        out_ready = 1'b1; key_n = 2'b11;
        switch_avg = 1'b0; switch_delay = 1'b0; switch_noise = 1'b0;

        #12;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_channel", int'(out_channel), 0);
        chk("reset led", int'(led), 'h00F);
        chk("reset hex", int'(hex), 'h19);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (tv[i].rst) mid_reset();
            @(negedge clk_clk);
            switch_avg = tv[i].avg;
            switch_delay = tv[i].dly;
            repeat (4) @(negedge clk_clk);
            send_one(tv[i].din, tv[i].ch, tv[i].exp, $sformatf("vec%0d", i));
        end

        // gain control
        plain_reset();
        @(negedge clk_clk);
        switch_avg = 1'b0; switch_delay = 1'b0;
        repeat (4) @(negedge clk_clk);
        repeat (7) press(2'b01);
        chk("gain9 led", int'(led), 'h1FF);
        chk("gain9 hex", int'(hex), 'h10);
        send_one(30000, 0, 32767, "sat pos");
        send_one(-30000, 1, -32768, "sat neg");
        press(2'b10);
        chk("gain8 led", int'(led), 'h0FF);
        send_one(1000, 0, 2000, "gain8");
        press(2'b11);
        chk("both keys led", int'(led), 'h00F);
        chk("both keys hex", int'(hex), 'h19);
        repeat (5) press(2'b10);
        chk("gain0 led", int'(led), 0);
        chk("gain0 hex", int'(hex), 'h40);
        send_one(1000, 1, 0, "gain0");

        // backpressure: out_ready low for 5 cycles while streaming
        plain_reset();
        for (int k = 0; k < 12; k++) vals[k] = 1000 + 37 * k - (k % 3) * 700;
        sent = 0;
        for (int cyc = 0; cyc < 80 && rx_d.size() < 12; cyc++) begin
            @(negedge clk_clk);
            out_ready = !(cyc >= 8 && cyc <= 12);
            if (sent < 12) begin
                in_valid = 1'b1; in_data = 16'(vals[sent]); in_channel = 1'(sent % 2);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                rx_d.push_back(int'($signed(out_data)));
                rx_c.push_back(int'(out_channel));
            end
            if (cyc >= 8 && cyc <= 12) begin
                chk("stall in_ready", int'(in_ready), 0);
                chk("stall out_valid", int'(out_valid), 1);
                chk("stall hold data", int'($signed(out_data)), vals[5]);
            end
            @(posedge clk_clk);
            if (acc) sent++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("stream count", rx_d.size(), 12);
        for (int k = 0; k < 12 && k < rx_d.size(); k++) begin
            chk($sformatf("stream data%0d", k), rx_d[k], vals[k]);
            chk($sformatf("stream chan%0d", k), rx_c[k], k % 2);
        end

        // noise gate
        @(negedge clk_clk);
        switch_noise = 1'b1;
        repeat (4) @(negedge clk_clk);
`ifdef NOISE_GATE_EN
        send_one(50, 0, 0, "gate 50");
        send_one(-63, 1, 0, "gate -63");
        send_one(64, 0, 64, "gate 64");
        send_one(-64, 1, -64, "gate -64");
`else
        send_one(50, 0, 50, "nogate 50");
        send_one(-63, 1, -63, "nogate -63");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
